// File: rtl/palette_lut_if.sv
// palette_lut_if -- lookup / write / fade bundle for palette_lut.
//   master : drives idx, blank, wr_en, wr_idx, wr_rgb, fade_in, fade_out, frame_tick;
//            receives r, g, b, fade_busy, fade_done
//   slave  : the palette_lut side (directions reversed)
// wr_rgb is packed {r, g, b}, COMP_W bits per channel.
interface palette_lut_if #(
  parameter int IDX_W  = 3,
  parameter int COMP_W = 6
);
  logic [IDX_W-1:0]    idx;
  logic                blank;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [3*COMP_W-1:0] wr_rgb;
  logic                fade_in;
  logic                fade_out;
  logic                frame_tick;
  logic [COMP_W-1:0]   r;
  logic [COMP_W-1:0]   g;
  logic [COMP_W-1:0]   b;
  logic                fade_busy;
  logic                fade_done;

  modport master (
    output idx, blank, wr_en, wr_idx, wr_rgb, fade_in, fade_out, frame_tick,
    input  r, g, b, fade_busy, fade_done
  );

  modport slave (
    input  idx, blank, wr_en, wr_idx, wr_rgb, fade_in, fade_out, frame_tick,
    output r, g, b, fade_busy, fade_done
  );
endinterface

// File: rtl/palette_lut.sv
// palette_lut -- colour palette lookup with optional brightness fade engine.
//   clk, rst_n : clock, async active-low reset
//   bus        : palette_lut_if.slave (lookup idx/blank, palette write port,
//                fade controls, registered r/g/b, fade_busy/fade_done)
// One cycle from idx/blank/level to r/g/b. The palette resets to a grey ramp
// and is read-before-write when lookup and write hit the same entry.
// Build macro PALETTE_LUT_FADE_EN enables the fade FSM and per-channel
// scaling by level/2**FADE_W; without it the output is the raw entry.
module palette_lut #(
  parameter int IDX_W  = 3,
  parameter int COMP_W = 6,
  parameter int FADE_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  palette_lut_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;

  // lane 2 = r, 1 = g, 0 = b, matching the {r,g,b} packing of wr_rgb
  logic [ENTRIES-1:0][2:0][COMP_W-1:0] pal;
  logic [2:0][COMP_W-1:0]              entry;
  logic [2:0][COMP_W-1:0]              chan_q;

  function automatic logic [COMP_W-1:0] grey(input int i);
    return COMP_W'(i) << (COMP_W - IDX_W);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) pal[i] <= {3{grey(i)}};
    end else if (bus.wr_en) begin
      pal[bus.wr_idx] <= bus.wr_rgb;
    end
  end

  // combinational read of the pre-write contents gives read-before-write
  assign entry = pal[bus.idx];

`ifdef PALETTE_LUT_FADE_EN
  localparam logic [FADE_W:0] LVL_MAX = {1'b1, {FADE_W{1'b0}}};
  localparam logic [FADE_W:0] LVL_ONE = {{FADE_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_DOWN, ST_UP} state_t;

  state_t          state;
  logic [FADE_W:0] level;
  logic [FADE_W:0] dn_nxt;
  logic [FADE_W:0] up_nxt;
  logic            busy_q;
  logic            done_q;

  // level after this cycle's tick, saturating at the fade target
  always_comb begin
    dn_nxt = level;
    up_nxt = level;
    if (bus.frame_tick && level != '0)      dn_nxt = level - LVL_ONE;
    if (bus.frame_tick && level != LVL_MAX) up_nxt = level + LVL_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      level  <= LVL_MAX;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // start cycle never steps the level, even with a tick present
          if (bus.fade_out) begin
            state  <= ST_DOWN;
            busy_q <= 1'b1;
          end else if (bus.fade_in) begin
            state  <= ST_UP;
            busy_q <= 1'b1;
          end
        end
        ST_DOWN: begin
          if (bus.fade_in) begin
            state <= ST_UP;                 // re-target from current level
          end else begin
            level <= dn_nxt;
            if (dn_nxt == '0) begin         // also covers start-at-target
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        ST_UP: begin
          if (bus.fade_out) begin
            state <= ST_DOWN;
          end else begin
            level <= up_nxt;
            if (up_nxt == LVL_MAX) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fade_busy = busy_q;
  assign bus.fade_done = done_q;
`else
  localparam int unused_fade_w = FADE_W;
  logic unused_fade;
  assign unused_fade   = ^{bus.fade_in, bus.fade_out, bus.frame_tick};
  assign bus.fade_busy = 1'b0;
  assign bus.fade_done = 1'b0;
`endif

  for (genvar c = 0; c < 3; c++) begin : g_lane
    logic [COMP_W-1:0] scaled;
    logic [COMP_W-1:0] q;
`ifdef PALETTE_LUT_FADE_EN
    // comp * level < 2**(COMP_W+FADE_W) since level <= 2**FADE_W
    logic [COMP_W+FADE_W-1:0] prod;
    assign prod   = {{FADE_W{1'b0}}, entry[c]} * {{(COMP_W-1){1'b0}}, level};
    assign scaled = COMP_W'(prod >> FADE_W);
`else
    assign scaled = entry[c];
`endif
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         q <= '0;
      else if (bus.blank) q <= '0;
      else                q <= scaled;
    end
    assign chan_q[c] = q;
  end

  assign bus.r = chan_q[2];
  assign bus.g = chan_q[1];
  assign bus.b = chan_q[0];
endmodule

// File: tb/tb_palette_lut.sv
module tb_palette_lut;
  localparam int IDX_W   = 3;
  localparam int COMP_W  = 6;
  localparam int FADE_W  = 4;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int FMAX    = 1 << FADE_W;

  logic clk;
  logic rst_n;
  palette_lut_if #(.IDX_W(IDX_W), .COMP_W(COMP_W)) bus ();

  palette_lut #(.IDX_W(IDX_W), .COMP_W(COMP_W), .FADE_W(FADE_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---- reference model: palette contents, brightness level, fade target ----
  int m_pal [ENTRIES][3];   // [entry][0=r,1=g,2=b]
  int m_lvl;
  int m_tgt;                // -1 when no fade in progress
  int e_rgb [3];
  int e_busy;
  int e_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        for (int c = 0; c < 3; c++) m_pal[i][c] = i << (COMP_W - IDX_W);
      m_lvl  = FMAX;
      m_tgt  = -1;
      e_rgb  = '{0, 0, 0};
      e_busy = 0;
      e_done = 0;
    end else begin
      for (int c = 0; c < 3; c++)
        e_rgb[c] = bus.blank ? 0 : (m_pal[bus.idx][c] * m_lvl) / FMAX;
      e_done = 0;
`ifdef PALETTE_LUT_FADE_EN
      if (m_tgt < 0) begin
        if (bus.fade_out)     m_tgt = 0;
        else if (bus.fade_in) m_tgt = FMAX;
      end else if (m_tgt == 0 && bus.fade_in) begin
        m_tgt = FMAX;
      end else if (m_tgt == FMAX && bus.fade_out) begin
        m_tgt = 0;
      end else begin
        if (bus.frame_tick) m_lvl += (m_tgt > m_lvl) ? 1 : ((m_tgt < m_lvl) ? -1 : 0);
        if (m_lvl == m_tgt) begin
          m_tgt  = -1;
          e_done = 1;
        end
      end
`endif
      e_busy = (m_tgt >= 0) ? 1 : 0;
      if (bus.wr_en) begin
        m_pal[bus.wr_idx][0] = int'(bus.wr_rgb[3*COMP_W-1 -: COMP_W]);
        m_pal[bus.wr_idx][1] = int'(bus.wr_rgb[2*COMP_W-1 -: COMP_W]);
        m_pal[bus.wr_idx][2] = int'(bus.wr_rgb[COMP_W-1 -: COMP_W]);
      end
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cmp_r",    int'(bus.r),         e_rgb[0]);
      check("cmp_g",    int'(bus.g),         e_rgb[1]);
      check("cmp_b",    int'(bus.b),         e_rgb[2]);
      check("cmp_busy", int'(bus.fade_busy), e_busy);
      check("cmp_done", int'(bus.fade_done), e_done);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rgb_is(input string name, input int er, input int eg, input int eb);
    check({name, "_r"}, int'(bus.r), er);
    check({name, "_g"}, int'(bus.g), eg);
    check({name, "_b"}, int'(bus.b), eb);
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    cyc();
  endtask

  int steps [16];

  initial begin
    steps = '{59, 55, 51, 47, 43, 39, 35, 31, 27, 23, 19, 15, 11, 7, 3, 0};
    rst_n          = 1'b0;
    bus.idx        = '0;
    bus.blank      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_idx     = '0;
    bus.wr_rgb     = '0;
    bus.fade_in    = 1'b0;
    bus.fade_out   = 1'b0;
    bus.frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rgb_is("reset", 0, 0, 0);
    check("reset_busy", int'(bus.fade_busy), 0);
    check("reset_done", int'(bus.fade_done), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // grey ramp lookup
    bus.idx = 3'd5;
    cyc();
    rgb_is("grey5", 40, 40, 40);

    // same-cycle write and read return the old entry
    bus.wr_en  = 1'b1;
    bus.wr_idx = 3'd2;
    bus.wr_rgb = {6'd63, 6'd0, 6'd32};
    bus.idx    = 3'd2;
    cyc();
    bus.wr_en = 1'b0;
    rgb_is("rbw_old", 16, 16, 16);
    cyc();
    rgb_is("rbw_new", 63, 0, 32);

    bus.idx   = 3'd5;
    bus.blank = 1'b1;
    cyc();
    bus.blank = 1'b0;
    rgb_is("blank5", 0, 0, 0);

    // entry 7 full white
    bus.wr_en  = 1'b1;
    bus.wr_idx = 3'd7;
    bus.wr_rgb = {3{6'd63}};
    bus.idx    = 3'd7;
    cyc();
    bus.wr_en = 1'b0;
    cyc();
    rgb_is("white7", 63, 63, 63);
    bus.blank = 1'b1;
    cyc();
    bus.blank = 1'b0;
    rgb_is("blank7", 0, 0, 0);
    cyc();
    rgb_is("unblank7", 63, 63, 63);

`ifdef PALETTE_LUT_FADE_EN
    // full fade-out, with a palette write landing mid-fade
    bus.fade_out = 1'b1;
    cyc();
    bus.fade_out = 1'b0;
    check("fo_busy", int'(bus.fade_busy), 1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 8) begin
        bus.wr_en  = 1'b1;
        bus.wr_idx = 3'd3;
        bus.wr_rgb = {6'd10, 6'd20, 6'd30};
      end
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      bus.wr_en      = 1'b0;
      check("fo_done", int'(bus.fade_done), (k == 16) ? 1 : 0);
      check("fo_busy_k", int'(bus.fade_busy), (k == 16) ? 0 : 1);
      cyc();
      check("fo_level_r", int'(bus.r), steps[k-1]);
    end

    // both requests at level 0: fade_out wins, already at target
    bus.fade_in  = 1'b1;
    bus.fade_out = 1'b1;
    cyc();
    bus.fade_in  = 1'b0;
    bus.fade_out = 1'b0;
    check("both_busy", int'(bus.fade_busy), 1);
    check("both_nodone", int'(bus.fade_done), 0);
    cyc();
    check("both_done", int'(bus.fade_done), 1);
    check("both_idle", int'(bus.fade_busy), 0);
    cyc();
    check("both_done_clr", int'(bus.fade_done), 0);
    check("both_r0", int'(bus.r), 0);

    // tick alongside start request does not step
    bus.fade_in    = 1'b1;
    bus.frame_tick = 1'b1;
    cyc();
    bus.fade_in    = 1'b0;
    bus.frame_tick = 1'b0;
    cyc();
    check("start_tick_r", int'(bus.r), 0);
    repeat (16) tick();
    check("fi_full_r", int'(bus.r), 63);

    bus.idx = 3'd3;
    cyc();
    rgb_is("midfade_wr", 10, 20, 30);
    bus.idx = 3'd7;

    // fade_in while already at full level
    bus.fade_in = 1'b1;
    cyc();
    bus.fade_in = 1'b0;
    check("at_tgt_busy", int'(bus.fade_busy), 1);
    cyc();
    check("at_tgt_done", int'(bus.fade_done), 1);
    check("at_tgt_r", int'(bus.r), 63);

    // re-target at level 9
    bus.fade_out = 1'b1;
    cyc();
    bus.fade_out = 1'b0;
    repeat (7) tick();
    check("lvl9_r", int'(bus.r), 35);
    bus.fade_in = 1'b1;
    cyc();
    bus.fade_in = 1'b0;
    check("rt_busy", int'(bus.fade_busy), 1);
    check("rt_nodone", int'(bus.fade_done), 0);
    tick();
    check("lvl10_r", int'(bus.r), 39);
    for (int k = 1; k <= 6; k++) begin
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      check("rt_done", int'(bus.fade_done), (k == 6) ? 1 : 0);
      cyc();
    end
    check("rt_full_r", int'(bus.r), 63);

    // start a fade that reset will abandon
    bus.fade_out = 1'b1;
    cyc();
    bus.fade_out = 1'b0;
    repeat (3) tick();
    check("lvl13_r", int'(bus.r), 51);
`else
    // fade controls have no effect
    bus.fade_out   = 1'b1;
    bus.frame_tick = 1'b1;
    cyc();
    bus.fade_out = 1'b0;
    repeat (4) cyc();
    bus.fade_in = 1'b1;
    cyc();
    bus.fade_in    = 1'b0;
    bus.frame_tick = 1'b0;
    cyc();
    rgb_is("nofade", 63, 63, 63);
    check("nofade_busy", int'(bus.fade_busy), 0);
    check("nofade_done", int'(bus.fade_done), 0);
`endif

    // async reset clears outputs without waiting for an edge
    rst_n = 1'b0;
    #1;
    rgb_is("async_rst", 0, 0, 0);
    check("async_rst_busy", int'(bus.fade_busy), 0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("post_rst_done", int'(bus.fade_done), 0);
    end
    rgb_is("post_rst_grey7", 56, 56, 56);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
